// File: rtl/sram_ctrl_pkg.sv
// Shared defaults, state encoding and request record for the SRAM request controller.
package sram_ctrl_pkg;

  localparam int unsigned DEF_ADDR_WD   = 8;
  localparam int unsigned DEF_DATA_WD   = 8;
  localparam int unsigned DEF_DEPTH     = 256;
  localparam int unsigned DEF_RSP_DEPTH = 4;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  typedef struct packed {
    logic                   write;
    logic [DEF_ADDR_WD-1:0] addr;
    logic [DEF_DATA_WD-1:0] data;
  } req_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Synchronous response FIFO; push and pop on the same edge are accepted even when full.
module sram_rsp_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic             empty,
  output logic             full
);

  localparam int unsigned        PTR_WD   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned        CNT_WD   = $clog2(DEPTH + 1);
  localparam logic [PTR_WD-1:0]  LAST     = PTR_WD'(DEPTH - 1);
  localparam logic [CNT_WD-1:0]  FULL_CNT = CNT_WD'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [PTR_WD-1:0] wrPtr;
  logic [PTR_WD-1:0] rdPtr;
  logic [CNT_WD-1:0] count;
  logic              doPush;
  logic              doPop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign doPop   = pop && !empty;
  assign doPush  = push && (!full || doPop);
  assign popData = empty ? '0 : mem[rdPtr];

  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= (wrPtr == LAST) ? '0 : wrPtr + PTR_WD'(1);
      if (doPop)  rdPtr <= (rdPtr == LAST) ? '0 : rdPtr + PTR_WD'(1);
      if (doPush && !doPop)      count <= count + CNT_WD'(1);
      else if (doPop && !doPush) count <= count - CNT_WD'(1);
    end
  end

endmodule

// File: rtl/sram_ctrl.sv
// Request-side controller for a synchronous SRAM with credit-limited read responses.
// SRAM_CTRL_INIT_EN enables a post-reset sweep writing INIT_VALUE to every location.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned          ADDR_WD    = DEF_ADDR_WD,
  parameter int unsigned          DATA_WD    = DEF_DATA_WD,
  parameter int unsigned          DEPTH      = DEF_DEPTH,
  parameter int unsigned          RSP_DEPTH  = DEF_RSP_DEPTH,
  parameter logic [DATA_WD-1:0]   INIT_VALUE = '0
) (
  input  logic               clock,
  input  logic               resetN,
  input  logic               reqValid,
  output logic               reqReady,
  input  logic               reqWrite,
  input  logic [ADDR_WD-1:0] reqAddr,
  input  logic [DATA_WD-1:0] reqData,
  output logic               rspValid,
  input  logic               rspReady,
  output logic [DATA_WD-1:0] rspData,
  output logic [ADDR_WD-1:0] ramAddr,
  output logic [DATA_WD-1:0] ramWrData,
  output logic               ramChipSel,
  output logic               ramRead,
  output logic               ramWrite,
  input  logic [DATA_WD-1:0] ramRdData,
  output logic               initDone
);

  localparam int unsigned       OUT_WD  = $clog2(RSP_DEPTH + 1);
  localparam logic [OUT_WD-1:0] CREDITS = OUT_WD'(RSP_DEPTH);

  state_t            state;
  logic [OUT_WD-1:0] outstanding;
  logic              rdPend1;
  logic              rdPend2;
  logic              accept;
  logic              rdAccept;
  logic              pop;
  logic              fifoEmpty;
  logic              fifoFull;
  req_t              req;

`ifdef SRAM_CTRL_INIT_EN
  localparam int unsigned         SWEEP_WD   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SWEEP_WD-1:0] LAST_SWEEP = SWEEP_WD'(DEPTH - 1);
  logic [SWEEP_WD-1:0] sweep;
`else
  logic unusedCfg;
  assign unusedCfg = ^{INIT_VALUE, DEPTH};
`endif

  assign req      = '{write: reqWrite, addr: reqAddr, data: reqData};
  assign reqReady = (state == RUN) && (outstanding < CREDITS);
  assign accept   = reqValid && reqReady;
  assign rdAccept = accept && !reqWrite;
  assign rspValid = !fifoEmpty;
  assign pop      = rspValid && rspReady;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state       <= INIT;
      initDone    <= 1'b0;
      ramChipSel  <= 1'b0;
      ramRead     <= 1'b0;
      ramWrite    <= 1'b0;
      ramAddr     <= '0;
      ramWrData   <= '0;
      rdPend1     <= 1'b0;
      rdPend2     <= 1'b0;
      outstanding <= '0;
`ifdef SRAM_CTRL_INIT_EN
      sweep       <= '0;
`endif
    end else begin
      // rdPend1 mirrors the read strobe; rdPend2 marks the cycle SRAM data is valid
      rdPend1 <= rdAccept;
      rdPend2 <= rdPend1;
      if (rdAccept && !pop)      outstanding <= outstanding + OUT_WD'(1);
      else if (pop && !rdAccept) outstanding <= outstanding - OUT_WD'(1);

      case (state)
        INIT: begin
`ifdef SRAM_CTRL_INIT_EN
          ramChipSel <= 1'b1;
          ramRead    <= 1'b0;
          ramWrite   <= 1'b1;
          ramAddr    <= ADDR_WD'(sweep);
          ramWrData  <= INIT_VALUE;
          sweep      <= sweep + SWEEP_WD'(1);
          if (sweep == LAST_SWEEP) begin
            state    <= RUN;
            initDone <= 1'b1;
          end
`else
          ramChipSel <= 1'b0;
          ramRead    <= 1'b0;
          ramWrite   <= 1'b0;
          state      <= RUN;
          initDone   <= 1'b1;
`endif
        end
        RUN: begin
          ramChipSel <= accept;
          ramRead    <= rdAccept;
          ramWrite   <= accept && req.write;
          if (accept) begin
            ramAddr   <= req.addr;
            ramWrData <= req.data;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  // Credits guarantee a push never meets a full FIFO without a simultaneous pop
  always_ff @(posedge clock) begin
    if (resetN) assert (!(rdPend2 && fifoFull && !pop));
  end

  sram_rsp_fifo #(
    .WIDTH(DATA_WD),
    .DEPTH(RSP_DEPTH)
  ) u_rsp_fifo (
    .clock    (clock),
    .resetN   (resetN),
    .push     (rdPend2),
    .pushData (ramRdData),
    .pop      (pop),
    .popData  (rspData),
    .empty    (fifoEmpty),
    .full     (fifoFull)
  );

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl with a behavioural 8x256 synchronous SRAM model.
// Expectations follow SRAM_CTRL_INIT_EN when the bench is built with that macro.
module tb_sram_ctrl;

  logic       clock = 1'b0;
  logic       resetN;
  logic       reqValid, reqReady, reqWrite;
  logic [7:0] reqAddr, reqData;
  logic       rspValid, rspReady;
  logic [7:0] rspData;
  logic [7:0] ramAddr, ramWrData, ramRdData;
  logic       ramChipSel, ramRead, ramWrite;
  logic       initDone;

  int checks = 0;
  int errors = 0;

`ifdef SRAM_CTRL_INIT_EN
  localparam int          INIT_CYC    = 256;
  localparam logic [10:0] INIT_STROBE = 11'b110_0000_0000;
  localparam logic [7:0]  EXP00       = 8'h00;
  localparam logic [7:0]  EXPFF       = 8'h00;
  localparam bit          SWEEP       = 1'b1;
`else
  localparam int          INIT_CYC    = 1;
  localparam logic [10:0] INIT_STROBE = 11'b000_0000_0000;
  localparam logic [7:0]  EXP00       = 8'h5A;
  localparam logic [7:0]  EXPFF       = 8'hA5;
  localparam bit          SWEEP       = 1'b0;
`endif

  always #5 clock = ~clock;

  logic [7:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
  always @(posedge clock) begin
    if (ramChipSel) begin
      if (ramWrite) mem[ramAddr] <= ramWrData;
      if (ramRead)  ramRdData    <= mem[ramAddr];
    end
  end

  sram_ctrl dut (
    .clock(clock), .resetN(resetN),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqAddr(reqAddr), .reqData(reqData),
    .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData),
    .ramAddr(ramAddr), .ramWrData(ramWrData), .ramChipSel(ramChipSel),
    .ramRead(ramRead), .ramWrite(ramWrite), .ramRdData(ramRdData),
    .initDone(initDone)
  );

  function automatic logic [7:0] pre(input logic [7:0] a);
    return SWEEP ? 8'h00 : (a ^ 8'h5A);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [7:0] a, input logic [7:0] d);
    int n = 0;
    reqValid = 1'b1; reqWrite = wr; reqAddr = a; reqData = d;
    while (!reqReady && n < 400) begin tick(); n++; end
    check("issue_ready", 32'(reqReady), 32'd1);
    tick();
    reqValid = 1'b0;
    check("strobe_cs", 32'(ramChipSel), 32'd1);
    check("strobe_rw", 32'({ramRead, ramWrite}), wr ? 32'd1 : 32'd2);
    check("strobe_addr", 32'(ramAddr), 32'(a));
    if (wr) check("strobe_wdata", 32'(ramWrData), 32'(d));
  endtask

  task automatic wait_rsp(input string name, input logic [7:0] exp, input int lat);
    int n = 0;
    while (!rspValid && n < 20) begin tick(); n++; end
    check({name, "_lat"}, 32'(n), 32'(lat));
    check({name, "_data"}, 32'(rspData), 32'(exp));
  endtask

  task automatic do_reset;
    int n = 0;
    resetN = 1'b0;
    #1;
    check("rst_outputs", 32'({rspValid, reqReady, ramChipSel, ramRead, ramWrite, initDone}), 32'd0);
    check("rst_rspdata", 32'(rspData), 32'd0);
    tick(); tick();
    #1 resetN = 1'b1;
    do begin
      tick(); n++;
      if (n == 1) check("init_strobe", 32'({ramChipSel, ramWrite, ramRead, ramAddr}), 32'(INIT_STROBE));
      if (rspValid) check("stale_rsp", 32'(rspValid), 32'd0);
    end while (!reqReady && n < 400);
    check("init_cycles", 32'(n), 32'(INIT_CYC));
    check("init_done", 32'(initDone), 32'd1);
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int issued, got, cyc, acceptEnd, firstR, lastR, popCyc, readyCyc;
    bit sawRsp;

    vecs[0] = '{1'b0, 8'h00, 8'h00, EXP00};
    vecs[1] = '{1'b0, 8'hFF, 8'h00, EXPFF};
    vecs[2] = '{1'b1, 8'h10, 8'hA5, 8'h00};
    vecs[3] = '{1'b0, 8'h10, 8'h00, 8'hA5};
    vecs[4] = '{1'b1, 8'h20, 8'h3C, 8'h00};
    vecs[5] = '{1'b0, 8'h20, 8'h00, 8'h3C};
    vecs[6] = '{1'b1, 8'h20, 8'hC3, 8'h00};
    vecs[7] = '{1'b0, 8'h20, 8'h00, 8'hC3};
    vecs[8] = '{1'b0, 8'h10, 8'h00, 8'hA5};

    reqValid = 1'b0; reqWrite = 1'b0; reqAddr = '0; reqData = '0; rspReady = 1'b1;
    resetN = 1'b0;
    #12;
    do_reset();

    // single transactions, write-then-read on consecutive clocks
    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].wr, vecs[i].addr, vecs[i].data);
      if (!vecs[i].wr) wait_rsp("vec", vecs[i].exp, 2);
    end
    tick();
    sawRsp = 1'b0;
    for (int i = 0; i < 3; i++) begin sawRsp |= rspValid; tick(); end
    check("idle_no_rsp", 32'(sawRsp), 32'd0);

    // back-to-back reads of 0x01..0x08
    reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 8'h01;
    issued = 0; got = 0; cyc = 0; acceptEnd = -1; firstR = -1; lastR = -1;
    while ((issued < 8 || got < 8) && cyc < 60) begin
      automatic logic acc = reqValid && reqReady;
      if (rspValid && rspReady) begin
        check("b2b_data", 32'(rspData), 32'(pre(8'(got + 1))));
        if (firstR < 0) firstR = cyc;
        lastR = cyc;
        got++;
      end
      tick(); cyc++;
      if (acc) begin
        issued++;
        if (issued == 8) begin reqValid = 1'b0; acceptEnd = cyc; end
        else reqAddr = 8'(issued + 1);
      end
    end
    check("b2b_accept_edges", 32'(acceptEnd), 32'd8);
    check("b2b_first_rsp", 32'(firstR), 32'd3);
    check("b2b_rsp_span", 32'(lastR - firstR), 32'd7);

    // credit limit with a stalled consumer
    for (int i = 0; i < 6; i++) issue(1'b1, 8'(8'h31 + i), 8'(i + 1));
    rspReady = 1'b0;
    reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 8'h31;
    issued = 0;
    for (int c = 0; c < 12; c++) begin
      automatic logic acc = reqValid && reqReady;
      tick();
      if (acc) begin issued++; reqAddr = 8'(8'h31 + issued); end
    end
    check("stall_accepts", 32'(issued), 32'd4);
    check("stall_ready", 32'(reqReady), 32'd0);
    check("stall_head", 32'({rspValid, rspData}), 32'h101);
    rspReady = 1'b1;
    got = 0; cyc = 0; popCyc = -1; readyCyc = -1;
    while ((issued < 6 || got < 6) && cyc < 40) begin
      automatic logic acc = reqValid && reqReady;
      if (reqReady && readyCyc < 0) readyCyc = cyc;
      if (rspValid && rspReady) begin
        check("stall_data", 32'(rspData), 32'(got + 1));
        if (popCyc < 0) popCyc = cyc;
        got++;
      end
      tick(); cyc++;
      if (acc) begin
        issued++;
        if (issued == 6) reqValid = 1'b0;
        else reqAddr = 8'(8'h31 + issued);
      end
    end
    check("stall_total", 32'({issued[7:0], got[7:0]}), 32'h0606);
    check("stall_ready_after_pop", 32'(readyCyc - popCyc), 32'd1);

    // reset with reads in flight
    reqValid = 1'b1; reqWrite = 1'b0;
    for (int i = 0; i < 3; i++) begin
      reqAddr = (i == 0) ? 8'h10 : (i == 1) ? 8'h20 : 8'h31;
      tick();
    end
    reqValid = 1'b0;
    do_reset();
    sawRsp = 1'b0;
    for (int i = 0; i < 4; i++) begin sawRsp |= rspValid; tick(); end
    check("post_rst_no_rsp", 32'(sawRsp), 32'd0);
    issue(1'b0, 8'h10, 8'h00);
    wait_rsp("post_rst_10", SWEEP ? 8'h00 : 8'hA5, 2);
    tick();
    issue(1'b0, 8'h36, 8'h00);
    wait_rsp("post_rst_36", SWEEP ? 8'h00 : 8'h06, 2);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
